// File: rtl/cfu_pkg.sv
// Shared definitions for the CFU SIMD arbiter: requester IDs and default widths.
package cfu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FUNC_W_DEF = 10;

  // Requester 0 is the CPU CFU port, requester 1 is the tile/loop sequencer
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_SEQ = 1'b1
  } reqId_t;

  // The round-robin pointer always moves to the requester that did not just win
  function automatic reqId_t otherReq(input reqId_t id);
    return (id == REQ_CPU) ? REQ_SEQ : REQ_CPU;
  endfunction

endpackage

// File: rtl/cfu_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each outstanding engine command.
module cfu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             pushOk, popOk;

  // A push is refused when full even if a pop happens in the same cycle
  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
    pushOk  = push_i & ~full_o;
    popOk   = pop_i & ~empty_o;
    count_o = count_q;
    head_o  = mem_q[rdPtr_q];
  end

  // Storage needs no reset; only entries below the count are ever read as valid
  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= data_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (popOk)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cfu_simd_arbiter.sv
// Round-robin sharing of one SIMD engine between the CPU CFU port and the sequencer,
// with zero-latency command forwarding and tag-based response routing.
module cfu_simd_arbiter
  import cfu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FUNC_W = FUNC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_cmd_valid,
  output logic              r0_cmd_ready,
  input  logic [FUNC_W-1:0] r0_cmd_function_id,
  input  logic [DATA_W-1:0] r0_cmd_inputs_0,
  input  logic [DATA_W-1:0] r0_cmd_inputs_1,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_rsp_outputs_0,
  input  logic              r1_cmd_valid,
  output logic              r1_cmd_ready,
  input  logic [FUNC_W-1:0] r1_cmd_function_id,
  input  logic [DATA_W-1:0] r1_cmd_inputs_0,
  input  logic [DATA_W-1:0] r1_cmd_inputs_1,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_rsp_outputs_0,
  output logic              eng_cmd_valid,
  input  logic              eng_cmd_ready,
  output logic [FUNC_W-1:0] eng_cmd_function_id,
  output logic [DATA_W-1:0] eng_cmd_inputs_0,
  output logic [DATA_W-1:0] eng_cmd_inputs_1,
  input  logic              eng_rsp_valid,
  output logic              eng_rsp_ready,
  input  logic [DATA_W-1:0] eng_rsp_outputs_0,
  output logic              busy,
  output logic              err_orphan_rsp
);

  reqId_t rrPtr_q, rrPtr_d;
  logic   lock_q, lock_d;
  reqId_t lockId_q, lockId_d;
  logic   errOrphan_q, errOrphan_d;

  reqId_t                grant;
  logic                  grantValid;
  logic                  cmdFire;
  logic                  rspPop;
  logic                  tagFull, tagEmpty;
  logic [$clog2(DEPTH):0] tagCount;
  logic [0:0]            headBits;
  reqId_t                head;

  // Grant: a presented-but-stalled command keeps its grant, else single valid wins, else round-robin
  always_comb begin
    grant = rrPtr_q;
    if (lock_q)                            grant = lockId_q;
    else if (r0_cmd_valid && !r1_cmd_valid) grant = REQ_CPU;
    else if (r1_cmd_valid && !r0_cmd_valid) grant = REQ_SEQ;
  end

  // Command path: mux the granted requester straight through to the engine
  always_comb begin
    grantValid          = (grant == REQ_SEQ) ? r1_cmd_valid : r0_cmd_valid;
    eng_cmd_valid       = grantValid & ~tagFull;
    cmdFire             = eng_cmd_valid & eng_cmd_ready;
    eng_cmd_function_id = (grant == REQ_SEQ) ? r1_cmd_function_id : r0_cmd_function_id;
    eng_cmd_inputs_0    = (grant == REQ_SEQ) ? r1_cmd_inputs_0 : r0_cmd_inputs_0;
    eng_cmd_inputs_1    = (grant == REQ_SEQ) ? r1_cmd_inputs_1 : r0_cmd_inputs_1;
    r0_cmd_ready        = (grant == REQ_CPU) & r0_cmd_valid & eng_cmd_ready & ~tagFull;
    r1_cmd_ready        = (grant == REQ_SEQ) & r1_cmd_valid & eng_cmd_ready & ~tagFull;
  end

  // Response path: route to the FIFO head, or swallow the response when nothing is outstanding
  always_comb begin
    head             = reqId_t'(headBits);
    r0_rsp_valid     = eng_rsp_valid & ~tagEmpty & (head == REQ_CPU);
    r1_rsp_valid     = eng_rsp_valid & ~tagEmpty & (head == REQ_SEQ);
    r0_rsp_outputs_0 = eng_rsp_outputs_0;
    r1_rsp_outputs_0 = eng_rsp_outputs_0;
    eng_rsp_ready    = tagEmpty ? 1'b1 : ((head == REQ_SEQ) ? r1_rsp_ready : r0_rsp_ready);
    rspPop           = eng_rsp_valid & eng_rsp_ready & ~tagEmpty;
    busy             = (tagCount != '0);
    err_orphan_rsp   = errOrphan_q;
  end

  // Next state: a fire hands priority to the other side; a stall pins the grant
  always_comb begin
    rrPtr_d     = rrPtr_q;
    lock_d      = lock_q;
    lockId_d    = lockId_q;
    errOrphan_d = errOrphan_q | (eng_rsp_valid & tagEmpty);
    if (cmdFire) begin
      rrPtr_d = otherReq(grant);
      lock_d  = 1'b0;
    end else if (eng_cmd_valid) begin
      lock_d   = 1'b1;
      lockId_d = grant;
    end
  end

  // Arbitration state and the sticky orphan flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrPtr_q     <= REQ_CPU;
      lock_q      <= 1'b0;
      lockId_q    <= REQ_CPU;
      errOrphan_q <= 1'b0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      lock_q      <= lock_d;
      lockId_q    <= lockId_d;
      errOrphan_q <= errOrphan_d;
    end
  end

  cfu_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (1)
  ) u_tagFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (cmdFire),
    .data_i  (grant),
    .pop_i   (rspPop),
    .full_o  (tagFull),
    .empty_o (tagEmpty),
    .count_o (tagCount),
    .head_o  (headBits)
  );

endmodule
